// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the match sequencer and the buttons, physics and renderer.
// master = buttons/physics side (drives events), slave = the sequencer (drives state).
interface pong_match_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic       point_p1;
    logic       point_p2;
    logic       ball_reset;
    logic       ball_run;
    logic       serve_dir;
    logic       sq_shown;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output frame_tick, start, pause, point_p1, point_p2,
        input  ball_reset, ball_run, serve_dir, sq_shown,
        input  score_p1, score_p2, game_over, state
    );

    modport slave (
        input  frame_tick, start, pause, point_p1, point_p2,
        output ball_reset, ball_run, serve_dir, sq_shown,
        output score_p1, score_p2, game_over, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match-flow sequencer: serve/play/point/over states, scoring, ball hold and blink.
// Latency: every output registered, an input sampled at edge N is visible after edge N.
// Backpressure: none, all events are single-cycle pulses; PONG_PAUSE_EN adds the PAUSE state.
module pong_match_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int BLINK_FRAMES = 8
) (
    input  logic              clk_0,
    input  logic              rst,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } state_t;

    localparam logic [3:0] WIN         = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST  = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST  = 8'(POINT_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);

    state_t     state_q, state_nxt;
    logic       start_q;
    logic       start_edge;
    logic [7:0] frame_cnt_q, frame_cnt_nxt;
    logic [7:0] blink_cnt_q, blink_cnt_nxt;
    logic [3:0] score_p1_q, score_p1_nxt;
    logic [3:0] score_p2_q, score_p2_nxt;
    logic [3:0] p1_inc, p2_inc;
    logic       serve_dir_q, serve_dir_nxt;
    logic       ball_reset_q, ball_reset_nxt;
    logic       ball_run_q, ball_run_nxt;
    logic       sq_shown_q, sq_shown_nxt;
    logic       game_over_q, game_over_nxt;
    logic       entering;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    assign start_edge = bus.start & ~start_q;

`ifdef PONG_PAUSE_EN
    logic pause_q;
    logic pause_edge;
    assign pause_edge = bus.pause & ~pause_q;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) pause_q <= 1'b0;
        else      pause_q <= bus.pause;
    end
`endif

    always_comb begin
        state_nxt     = state_q;
        score_p1_nxt  = score_p1_q;
        score_p2_nxt  = score_p2_q;
        serve_dir_nxt = serve_dir_q;
        p1_inc        = sat_inc(score_p1_q);
        p2_inc        = sat_inc(score_p2_q);

        case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_nxt     = SERVE;
                    score_p1_nxt  = 4'd0;
                    score_p2_nxt  = 4'd0;
                    serve_dir_nxt = 1'b0;
                end
            end
            SERVE: begin
                if (bus.frame_tick && frame_cnt_q == SERVE_LAST) state_nxt = PLAY;
            end
            PLAY: begin
                // A double hit is a dead ball: nobody scores, serve side unchanged.
                if (bus.point_p1 && bus.point_p2) begin
                    state_nxt = POINT;
                end else if (bus.point_p1) begin
                    score_p1_nxt  = p1_inc;
                    serve_dir_nxt = 1'b1;
                    state_nxt     = (p1_inc == WIN) ? OVER : POINT;
                end else if (bus.point_p2) begin
                    score_p2_nxt  = p2_inc;
                    serve_dir_nxt = 1'b0;
                    state_nxt     = (p2_inc == WIN) ? OVER : POINT;
                end
`ifdef PONG_PAUSE_EN
                else if (pause_edge) begin
                    state_nxt = PAUSE;
                end
`endif
            end
            POINT: begin
                if (bus.frame_tick && frame_cnt_q == POINT_LAST) state_nxt = SERVE;
            end
`ifdef PONG_PAUSE_EN
            PAUSE: begin
                if (pause_edge) state_nxt = PLAY;
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // Counters restart on the transition edge; a tick on that same edge is dropped.
        entering = (state_nxt != state_q);

        if (entering)             frame_cnt_nxt = 8'd0;
        else if (bus.frame_tick)  frame_cnt_nxt = frame_cnt_q + 8'd1;
        else                      frame_cnt_nxt = frame_cnt_q;

        if (entering)
            blink_cnt_nxt = 8'd0;
        else if (bus.frame_tick && state_q == SERVE)
            blink_cnt_nxt = (blink_cnt_q == BLINK_LAST) ? 8'd0 : blink_cnt_q + 8'd1;
        else
            blink_cnt_nxt = blink_cnt_q;

        if (state_nxt == SERVE) begin
            if (entering)
                sq_shown_nxt = 1'b1;
            else if (bus.frame_tick && blink_cnt_q == BLINK_LAST)
                sq_shown_nxt = ~sq_shown_q;
            else
                sq_shown_nxt = sq_shown_q;
        end else begin
            sq_shown_nxt = (state_nxt == PLAY) || (state_nxt == PAUSE);
        end

        ball_reset_nxt = entering && (state_nxt == SERVE);
        ball_run_nxt   = (state_nxt == PLAY);
        game_over_nxt  = (state_nxt == OVER);
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            frame_cnt_q  <= 8'd0;
            blink_cnt_q  <= 8'd0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            serve_dir_q  <= 1'b0;
            ball_reset_q <= 1'b0;
            ball_run_q   <= 1'b0;
            sq_shown_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            start_q      <= bus.start;
            frame_cnt_q  <= frame_cnt_nxt;
            blink_cnt_q  <= blink_cnt_nxt;
            score_p1_q   <= score_p1_nxt;
            score_p2_q   <= score_p2_nxt;
            serve_dir_q  <= serve_dir_nxt;
            ball_reset_q <= ball_reset_nxt;
            ball_run_q   <= ball_run_nxt;
            sq_shown_q   <= sq_shown_nxt;
            game_over_q  <= game_over_nxt;
        end
    end

    assign bus.ball_reset = ball_reset_q;
    assign bus.ball_run   = ball_run_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.sq_shown   = sq_shown_q;
    assign bus.score_p1   = score_p1_q;
    assign bus.score_p2   = score_p2_q;
    assign bus.game_over  = game_over_q;
    assign bus.state      = state_q;

endmodule
